pll_reset_sequencer: RTL and testbench

//  Power-up and recovery sequencer for the board PLL that turns the 50 MHz input into the 7 MHz core clock.

---
 rtl/pll_reset_sequencer_pkg.sv | 28 ++
 rtl/pll_reset_sequencer_sync_bit.sv | 26 ++
 rtl/pll_reset_sequencer.sv | 118 +++++++++++
 tb/tb_pll_reset_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_sequencer_pkg.sv
// Shared definitions for the PLL reset sequencer: state encodings and
// default timing constants, imported by the top level and its users so
// that every instance agrees on encodings and nominal timing.
package pll_reset_sequencer_pkg;

  // Sequencer states. Encodings are fixed so external debug taps and
  // logic analyser decodes stay stable across revisions.
  typedef enum logic [1:0] {
    RESET_PLL = 2'd0,
    WAIT_LOCK = 2'd1,
    STABLE    = 2'd2,
    RUN       = 2'd3
  } seq_state_e;

  // Nominal timing for a 50 MHz sequencing clock.
  localparam int DEF_RST_CYCLES    = 8;
  localparam int DEF_LOCK_TIMEOUT  = 50000;  // 1 ms
  localparam int DEF_STABLE_CYCLES = 1024;
  localparam int DEF_SYNC_STAGES   = 2;
  localparam int DEF_RETRY_W       = 4;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/pll_reset_sequencer_sync_bit.sv
// Purpose: multi-flop synchroniser for a single asynchronous level.
// Latency: STAGES clk edges from input change to q.
// Backpressure: none, free-running level path.
// Ports: clk, rst_n (async active-low clear), d (async input), q (synchronised).
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// Purpose: pulse PLL reset, wait for stable lock, then release system reset; retry on lock timeout.
// Latency: sys_reset_n/ready rise SYNC_STAGES+STABLE_CYCLES cycles after pll_locked is first sampled high.
// Backpressure: none; all outputs are registered levels/pulses on clock50.
// Ports: clock50, reset_n (async active-low), pll_locked (async), reboot (level request)
//        -> pll_reset, sys_reset_n, ready, lock_lost (1-cycle pulse), retries (saturating).
module pll_reset_sequencer
  import pll_reset_sequencer_pkg::*;
#(
  parameter int RST_CYCLES    = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES,
  parameter int RETRY_W       = DEF_RETRY_W
) (
  input  logic               clock50,
  input  logic               reset_n,
  input  logic               pll_locked,
  input  logic               reboot,
  output logic               pll_reset,
  output logic               sys_reset_n,
  output logic               ready,
  output logic               lock_lost,
  output logic [RETRY_W-1:0] retries
);

  localparam int MAX_CNT = max3(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
  localparam int CNT_W   = (MAX_CNT > 1) ? $clog2(MAX_CNT) : 1;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);

  seq_state_e       state, state_n;
  logic [CNT_W-1:0] cnt;
  logic             locked_s;
  logic             lost_n;
  logic             retry_inc;

  sync_bit #(.STAGES(SYNC_STAGES)) u_lock_sync (
    .clk   (clock50),
    .rst_n (reset_n),
    .d     (pll_locked),
    .q     (locked_s)
  );

  // Next-state: reboot beats lock events, which beat counter expiry.
  // reboot is deliberately not looked at in RESET_PLL so the pulse width is fixed.
  always_comb begin
    state_n   = state;
    lost_n    = 1'b0;
    retry_inc = 1'b0;
    case (state)
      RESET_PLL: begin
        if (cnt == RST_LAST) state_n = WAIT_LOCK;
      end
      WAIT_LOCK: begin
        if (reboot) begin
          state_n = RESET_PLL;
        end else if (locked_s) begin
          state_n = STABLE;
        end else if (cnt == LOCK_LAST) begin
          state_n   = RESET_PLL;
          retry_inc = 1'b1;
        end
      end
      STABLE: begin
        if (reboot) begin
          state_n = RESET_PLL;
        end else if (!locked_s) begin
          state_n = WAIT_LOCK;
        end else if (cnt == STABLE_LAST) begin
          state_n = RUN;
        end
      end
      RUN: begin
        if (reboot) begin
          state_n = RESET_PLL;
        end else if (!locked_s) begin
          // Lock dropped: hunt for lock again without re-pulsing the PLL.
          state_n = WAIT_LOCK;
          lost_n  = 1'b1;
        end
      end
      default: state_n = RESET_PLL;
    endcase
  end

  always_ff @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      state       <= RESET_PLL;
      cnt         <= '0;
      retries     <= '0;
      pll_reset   <= 1'b1;
      sys_reset_n <= 1'b0;
      ready       <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      state <= state_n;
      // Counter restarts on every state change; RUN has no terminal count,
      // so it is held there rather than left to wrap.
      if (state_n != state || state == RUN) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
      if (retry_inc && retries != '1) begin
        retries <= retries + 1'b1;
      end
      // Outputs decoded from next state so they are glitch-free flops that
      // change on the same edge as the state.
      pll_reset   <= (state_n == RESET_PLL);
      sys_reset_n <= (state_n == RUN);
      ready       <= (state_n == RUN);
      lock_lost   <= lost_n;
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Purpose: randomized + directed bench for pll_reset_sequencer with a phase/elapsed-time reference model.
// Latency: model predicts outputs after every clock50 edge; monitor compares half a cycle later.
// Backpressure: none; expectations queue between model and monitor.
module tb_pll_reset_sequencer;

  localparam int RSTC = 4;
  localparam int LTO  = 20;
  localparam int STC  = 8;
  localparam int SYNC = 2;
  localparam int RW   = 4;
  localparam int RMAX = (1 << RW) - 1;

  logic          clock50 = 1'b0;
  logic          reset_n;
  logic          pll_locked;
  logic          reboot;
  logic          pll_reset;
  logic          sys_reset_n;
  logic          ready;
  logic          lock_lost;
  logic [RW-1:0] retries;

  int vectors     = 0;
  int miscompares = 0;

  pll_reset_sequencer #(
    .RST_CYCLES    (RSTC),
    .LOCK_TIMEOUT  (LTO),
    .STABLE_CYCLES (STC),
    .SYNC_STAGES   (SYNC),
    .RETRY_W       (RW)
  ) dut (
    .clock50     (clock50),
    .reset_n     (reset_n),
    .pll_locked  (pll_locked),
    .reboot      (reboot),
    .pll_reset   (pll_reset),
    .sys_reset_n (sys_reset_n),
    .ready       (ready),
    .lock_lost   (lock_lost),
    .retries     (retries)
  );

  always #5 clock50 = ~clock50;

  // ---------------- reference model ----------------
  typedef enum {PH_PULSE, PH_HUNT, PH_SETTLE, PH_RUN} phase_e;
  typedef struct {
    bit pr;
    bit sr;
    bit rd;
    bit ll;
    int rt;
  } exp_t;

  exp_t   expq[$];
  phase_e ph = PH_PULSE;
  int     age = 0;        // full cycles already spent in current phase
  int     tries = 0;
  bit     lost = 0;
  bit     seen[$];        // pll_locked samples, oldest first

  function automatic exp_t snapshot();
    exp_t e;
    e.pr = (ph == PH_PULSE);
    e.sr = (ph == PH_RUN);
    e.rd = (ph == PH_RUN);
    e.ll = lost;
    e.rt = tries;
    return e;
  endfunction

  always @(posedge clock50 or negedge reset_n) begin
    if (!reset_n) begin
      ph = PH_PULSE;
      age = 0;
      tries = 0;
      lost = 0;
      seen.delete();
      for (int i = 0; i < SYNC; i++) seen.push_back(1'b0);
    end else begin
      bit     ls;
      phase_e nx;
      ls = seen[0];
      seen.push_back(pll_locked);
      void'(seen.pop_front());
      lost = 0;
      nx = ph;
      case (ph)
        PH_PULSE:  if (age + 1 == RSTC) nx = PH_HUNT;
        PH_HUNT: begin
          if (reboot) nx = PH_PULSE;
          else if (ls) nx = PH_SETTLE;
          else if (age + 1 == LTO) begin
            nx = PH_PULSE;
            if (tries < RMAX) tries++;
          end
        end
        PH_SETTLE: begin
          if (reboot) nx = PH_PULSE;
          else if (!ls) nx = PH_HUNT;
          else if (age + 1 == STC) nx = PH_RUN;
        end
        PH_RUN: begin
          if (reboot) nx = PH_PULSE;
          else if (!ls) begin
            nx = PH_HUNT;
            lost = 1;
          end
        end
        default: nx = PH_PULSE;
      endcase
      age = (nx != ph) ? 0 : age + 1;
      ph = nx;
    end
    expq.push_back(snapshot());
  end

  // ---------------- monitor ----------------
  task automatic cmp(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, req, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clock50 or negedge reset_n);
      #1;
      if (expq.size() > 0) begin
        exp_t e;
        while (expq.size() > 1) void'(expq.pop_front());
        e = expq.pop_front();
        cmp("pll_reset", int'(pll_reset), int'(e.pr));
        cmp("sys_reset_n", int'(sys_reset_n), int'(e.sr));
        cmp("ready", int'(ready), int'(e.rd));
        cmp("lock_lost", int'(lock_lost), int'(e.ll));
        cmp("retries", int'(retries), e.rt);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock50);
    #1;
  endtask

  task automatic wait_ready(input string name, input int budget);
    int n = 0;
    while (!ready && n < budget) begin
      tick(1);
      n++;
    end
    vectors++;
    if (!ready) begin
      miscompares++;
      $display("FAIL %s: ready still %0d after %0d cycles, expected 1", name, ready, budget);
    end
  endtask

  task automatic wait_pll_low(input string name, input int budget);
    int n = 0;
    while (pll_reset && n < budget) begin
      tick(1);
      n++;
    end
    vectors++;
    if (pll_reset) begin
      miscompares++;
      $display("FAIL %s: pll_reset still %0d after %0d cycles, expected 0", name, pll_reset, budget);
    end
  endtask

  initial begin
    reset_n    = 1'b0;
    pll_locked = 1'b0;
    reboot     = 1'b0;
    tick(3);
    reset_n = 1'b1;

    // Power-up: lock arrives 3 cycles after the PLL reset pulse ends.
    wait_pll_low("powerup_pulse", 20);
    tick(3);
    pll_locked = 1'b1;
    wait_ready("powerup_release", 60);

    // Lock loss in RUN, then restoration.
    tick(5);
    pll_locked = 1'b0;
    tick(6);
    pll_locked = 1'b1;
    wait_ready("relock_release", 60);

    // Reboot from RUN, with a second reboot inside the PLL reset pulse.
    tick(4);
    reboot = 1'b1;
    tick(1);
    reboot = 1'b0;
    tick(1);
    reboot = 1'b1;
    tick(1);
    reboot = 1'b0;
    wait_ready("reboot_release", 80);

    // One-cycle lock glitch while in STABLE.
    reboot = 1'b1;
    tick(1);
    reboot = 1'b0;
    tick(RSTC + SYNC + 3);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    wait_ready("glitch_release", 80);

    // No lock at all: retries climb and saturate.
    pll_locked = 1'b0;
    tick((RSTC + LTO) * (RMAX + 3));

    // Randomized lock behaviour and reboots.
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 29) == 0) pll_locked = ~pll_locked;
      if (reboot) reboot = ($urandom_range(0, 2) != 0);
      else        reboot = ($urandom_range(0, 119) == 0);
      tick(1);
    end
    reboot = 1'b0;

    // Asynchronous reset assertion in the middle of RUN.
    pll_locked = 1'b1;
    wait_ready("pre_async_reset", 200);
    tick(3);
    #2;
    reset_n = 1'b0;
    #2;
    tick(2);
    reset_n = 1'b1;
    wait_ready("post_async_reset", 80);
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
